// File: rtl/dlx_pkg.sv
// dlx_pkg
// Shared encodings for the DLX instruction decode stage:
//   - primary opcodes (instruction bits [31:26]) and R-type funct codes ([5:0])
//   - 4-bit ALU operation enum
//   - PC command / PC target encodings
//   - immediate-extension modes used by dlx_imm_ext
//   - the decoded control bundle and its NOP value (all zeros)
package dlx_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_SLEI  = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_SRA = 6'h07;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SEQ = 6'h28;
  localparam logic [5:0] FN_SNE = 6'h29;
  localparam logic [5:0] FN_SLE = 6'h2C;
  localparam logic [5:0] FN_SLT = 6'h2F;

  // ALU operation; codes 12-15 are unused
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_AND = 4'd1,
    ALU_OR  = 4'd2,
    ALU_SEQ = 4'd3,
    ALU_SLE = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SNE = 4'd7,
    ALU_SRA = 4'd8,
    ALU_SRL = 4'd9,
    ALU_SUB = 4'd10,
    ALU_XOR = 4'd11
  } alu_op_t;

  // PC unit command
  localparam logic [1:0] PC_CMD_SEQ  = 2'b00;
  localparam logic [1:0] PC_CMD_BEQZ = 2'b01;
  localparam logic [1:0] PC_CMD_BNEZ = 2'b10;
  localparam logic [1:0] PC_CMD_JUMP = 2'b11;

  // PC target select; 10/11 are reserved and never produced
  localparam logic [1:0] PC_VAL_REL = 2'b00;
  localparam logic [1:0] PC_VAL_REG = 2'b01;

  // Immediate extension modes
  typedef enum logic [1:0] {
    IMM_SEXT16 = 2'd0,
    IMM_ZEXT16 = 2'd1,
    IMM_HI16   = 2'd2,
    IMM_SEXT26 = 2'd3
  } imm_mode_t;

  // Decoded control bundle, one entry per registered output
  typedef struct packed {
    logic        d_write_enable;
    logic        d_load_enable;
    logic        iv_alu;
    logic        pc_alu;
    logic [1:0]  pc_cmd;
    logic [1:0]  pc_val;
    alu_op_t     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] iv;
  } ctrl_t;

  // All-zero control word is a NOP: no store, no load, no writeback, PC sequential
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/dlx_imm_ext.sv
// dlx_imm_ext
// Combinational immediate extender for the DLX decode stage.
// Ports:
//   imm  in  16  I-type immediate (instruction bits [15:0])
//   off  in  26  J-type offset (instruction bits [25:0])
//   mode in   2  extension mode (imm_mode_t)
//   ext  out 32  extended immediate
module dlx_imm_ext
  import dlx_pkg::*;
(
  input  logic [15:0] imm,
  input  logic [25:0] off,
  input  imm_mode_t   mode,
  output logic [31:0] ext
);

  always_comb begin
    ext = '0;
    case (mode)
      IMM_SEXT16: ext = {{16{imm[15]}}, imm};
      IMM_ZEXT16: ext = {16'h0000, imm};
      IMM_HI16:   ext = {imm, 16'h0000};
      IMM_SEXT26: ext = {{6{off[25]}}, off};
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/dlx_decoder.sv
// dlx_decoder
// DLX instruction decode stage. The fetched word is decoded combinationally
// and captured into output flops whenever ID is high (one-cycle latency).
// Unrecognised opcodes or R-type functs decode as a NOP (all outputs 0).
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous active-high reset (outputs -> NOP)
//   ID             in   1  decode enable; outputs load only when 1
//   i_data_read    in  32  fetched instruction
//   d_write_enable out  1  data-memory store (SW)
//   d_load_enable  out  1  data-memory load (LW)
//   Iv_alu         out  1  ALU operand B = Iv
//   Pc_alu         out  1  ALU operand A = PC
//   Pc_cmd         out  2  PC command
//   Pc_val         out  2  PC target select
//   I              out  4  ALU operation
//   Rs1, Rs2, Rd   out  5  register indices (Rd=0: no writeback)
//   Iv             out 32  extended immediate
//   illegal        out  1  unrecognised instruction flag
//                          (only when DLX_DECODER_ILLEGAL_EN is defined)
module dlx_decoder
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ID,
  input  logic [31:0] i_data_read,
  output logic        d_write_enable,
  output logic        d_load_enable,
  output logic        Iv_alu,
  output logic        Pc_alu,
  output logic [1:0]  Pc_cmd,
  output logic [1:0]  Pc_val,
  output logic [3:0]  I,
`ifdef DLX_DECODER_ILLEGAL_EN
  output logic        illegal,
`endif
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic [4:0]  Rd,
  output logic [31:0] Iv
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  f_rs1;
  logic [4:0]  f_rs2;
  logic [4:0]  f_rd;
  imm_mode_t   imm_mode;
  logic        use_imm;
  logic        illegal_d;
  logic [31:0] imm_ext;
  ctrl_t       ctrl_d;
  ctrl_t       ctrl_q;

  assign opcode = i_data_read[31:26];
  assign funct  = i_data_read[5:0];
  assign f_rs1  = i_data_read[25:21];
  assign f_rs2  = i_data_read[20:16];
  assign f_rd   = i_data_read[15:11];

  dlx_imm_ext u_imm_ext (
    .imm  (i_data_read[15:0]),
    .off  (i_data_read[25:0]),
    .mode (imm_mode),
    .ext  (imm_ext)
  );

  // Decode. Every path starts from the NOP bundle; I-type instructions then
  // take Rs1/Rd from [25:21]/[20:16] and select B = Iv. Iv is only taken
  // from the extender when use_imm is set, so R-type and NOP keep Iv = 0.
  always_comb begin
    ctrl_d    = CTRL_NOP;
    imm_mode  = IMM_SEXT16;
    use_imm   = 1'b0;
    illegal_d = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        ctrl_d.rs1 = f_rs1;
        ctrl_d.rs2 = f_rs2;
        ctrl_d.rd  = f_rd;
        case (funct)
          FN_ADD:  ctrl_d.alu_op = ALU_ADD;
          FN_AND:  ctrl_d.alu_op = ALU_AND;
          FN_OR:   ctrl_d.alu_op = ALU_OR;
          FN_SEQ:  ctrl_d.alu_op = ALU_SEQ;
          FN_SLE:  ctrl_d.alu_op = ALU_SLE;
          FN_SLL:  ctrl_d.alu_op = ALU_SLL;
          FN_SLT:  ctrl_d.alu_op = ALU_SLT;
          FN_SNE:  ctrl_d.alu_op = ALU_SNE;
          FN_SRA:  ctrl_d.alu_op = ALU_SRA;
          FN_SRL:  ctrl_d.alu_op = ALU_SRL;
          FN_SUB:  ctrl_d.alu_op = ALU_SUB;
          FN_XOR:  ctrl_d.alu_op = ALU_XOR;
          default: begin
            ctrl_d    = CTRL_NOP;
            illegal_d = 1'b1;
          end
        endcase
      end

      // JAL's link value is produced by the PC unit; Iv stays the offset.
      OP_J, OP_JAL: begin
        imm_mode      = IMM_SEXT26;
        use_imm       = 1'b1;
        ctrl_d.pc_cmd = PC_CMD_JUMP;
        ctrl_d.pc_val = PC_VAL_REL;
        if (opcode == OP_JAL) begin
          ctrl_d.rd     = 5'd31;
          ctrl_d.pc_alu = 1'b1;
          ctrl_d.iv_alu = 1'b1;
        end
      end

      OP_ADDI, OP_SUBI, OP_SEQI, OP_SLEI, OP_SLTI, OP_SNEI,
      OP_LW, OP_SW, OP_BEQZ, OP_BNEZ, OP_JR, OP_JALR: begin
        imm_mode      = IMM_SEXT16;
        use_imm       = 1'b1;
        ctrl_d.iv_alu = 1'b1;
        ctrl_d.rs1    = f_rs1;
        ctrl_d.rd     = f_rs2;
        case (opcode)
          OP_SUBI: ctrl_d.alu_op = ALU_SUB;
          OP_SEQI: ctrl_d.alu_op = ALU_SEQ;
          OP_SLEI: ctrl_d.alu_op = ALU_SLE;
          OP_SLTI: ctrl_d.alu_op = ALU_SLT;
          OP_SNEI: ctrl_d.alu_op = ALU_SNE;
          OP_LW:   ctrl_d.d_load_enable = 1'b1;
          OP_SW: begin
            ctrl_d.d_write_enable = 1'b1;
            ctrl_d.rs2            = f_rs2;
            ctrl_d.rd             = 5'd0;
          end
          OP_BEQZ: begin
            ctrl_d.pc_cmd = PC_CMD_BEQZ;
            ctrl_d.rd     = 5'd0;
          end
          OP_BNEZ: begin
            ctrl_d.pc_cmd = PC_CMD_BNEZ;
            ctrl_d.rd     = 5'd0;
          end
          OP_JR: begin
            ctrl_d.pc_cmd = PC_CMD_JUMP;
            ctrl_d.pc_val = PC_VAL_REG;
            ctrl_d.rd     = 5'd0;
          end
          OP_JALR: begin
            ctrl_d.pc_cmd = PC_CMD_JUMP;
            ctrl_d.pc_val = PC_VAL_REG;
            ctrl_d.rd     = 5'd31;
            ctrl_d.pc_alu = 1'b1;
          end
          default: ctrl_d.alu_op = ALU_ADD;
        endcase
      end

      OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI: begin
        imm_mode      = IMM_ZEXT16;
        use_imm       = 1'b1;
        ctrl_d.iv_alu = 1'b1;
        ctrl_d.rs1    = f_rs1;
        ctrl_d.rd     = f_rs2;
        case (opcode)
          OP_ANDI: ctrl_d.alu_op = ALU_AND;
          OP_ORI:  ctrl_d.alu_op = ALU_OR;
          OP_XORI: ctrl_d.alu_op = ALU_XOR;
          OP_SLLI: ctrl_d.alu_op = ALU_SLL;
          OP_SRLI: ctrl_d.alu_op = ALU_SRL;
          default: ctrl_d.alu_op = ALU_SRA;
        endcase
      end

      OP_LHI: begin
        imm_mode      = IMM_HI16;
        use_imm       = 1'b1;
        ctrl_d.iv_alu = 1'b1;
        ctrl_d.rd     = f_rs2;
      end

      default: illegal_d = 1'b1;
    endcase

    if (use_imm) begin
      ctrl_d.iv = imm_ext;
    end
  end

  // Output register: reset forces a NOP and overrides ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= CTRL_NOP;
    end else if (ID) begin
      ctrl_q <= ctrl_d;
    end
  end

`ifdef DLX_DECODER_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (ID) begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  logic illegal_unused;
  assign illegal_unused = illegal_d;
`endif

  assign d_write_enable = ctrl_q.d_write_enable;
  assign d_load_enable  = ctrl_q.d_load_enable;
  assign Iv_alu         = ctrl_q.iv_alu;
  assign Pc_alu         = ctrl_q.pc_alu;
  assign Pc_cmd         = ctrl_q.pc_cmd;
  assign Pc_val         = ctrl_q.pc_val;
  assign I              = ctrl_q.alu_op;
  assign Rs1            = ctrl_q.rs1;
  assign Rs2            = ctrl_q.rs2;
  assign Rd             = ctrl_q.rd;
  assign Iv             = ctrl_q.iv;

endmodule

// File: tb/tb_dlx_decoder.sv
// tb_dlx_decoder
// Directed-vector bench for dlx_decoder. Expected values are hand-computed
// constants. Build with +define+DLX_DECODER_ILLEGAL_EN to cover the
// illegal flag as well.
module tb_dlx_decoder;

  logic        clk;
  logic        reset;
  logic        ID;
  logic [31:0] i_data_read;
  logic        d_write_enable;
  logic        d_load_enable;
  logic        Iv_alu;
  logic        Pc_alu;
  logic [1:0]  Pc_cmd;
  logic [1:0]  Pc_val;
  logic [3:0]  I;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  Rd;
  logic [31:0] Iv;
`ifdef DLX_DECODER_ILLEGAL_EN
  logic        illegal;
`endif

  int assertCount = 0;
  int failCount   = 0;

  dlx_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .ID             (ID),
    .i_data_read    (i_data_read),
    .d_write_enable (d_write_enable),
    .d_load_enable  (d_load_enable),
    .Iv_alu         (Iv_alu),
    .Pc_alu         (Pc_alu),
    .Pc_cmd         (Pc_cmd),
    .Pc_val         (Pc_val),
    .I              (I),
`ifdef DLX_DECODER_ILLEGAL_EN
    .illegal        (illegal),
`endif
    .Rs1            (Rs1),
    .Rs2            (Rs2),
    .Rd             (Rd),
    .Iv             (Iv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Field-by-field check of the whole registered output bundle.
  task automatic checkDecode(input string tag,
                             input logic dwe, input logic dle,
                             input logic ivalu, input logic pcalu,
                             input logic [1:0] pccmd, input logic [1:0] pcval,
                             input logic [3:0] op,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] iv,
                             input logic ill);
    checkOutput({tag, ".d_write_enable"}, 32'(d_write_enable), 32'(dwe));
    checkOutput({tag, ".d_load_enable"},  32'(d_load_enable),  32'(dle));
    checkOutput({tag, ".Iv_alu"},         32'(Iv_alu),         32'(ivalu));
    checkOutput({tag, ".Pc_alu"},         32'(Pc_alu),         32'(pcalu));
    checkOutput({tag, ".Pc_cmd"},         32'(Pc_cmd),         32'(pccmd));
    checkOutput({tag, ".Pc_val"},         32'(Pc_val),         32'(pcval));
    checkOutput({tag, ".I"},              32'(I),              32'(op));
    checkOutput({tag, ".Rs1"},            32'(Rs1),            32'(rs1));
    checkOutput({tag, ".Rs2"},            32'(Rs2),            32'(rs2));
    checkOutput({tag, ".Rd"},             32'(Rd),             32'(rd));
    checkOutput({tag, ".Iv"},             Iv,                  iv);
`ifdef DLX_DECODER_ILLEGAL_EN
    checkOutput({tag, ".illegal"},        32'(illegal),        32'(ill));
`else
    if (ill === 1'bx) $display("[TB] unexpected X in illegal expectation");
`endif
  endtask

  // Drive one word away from the active edge, clock it, sample 1 time unit later.
  task automatic applyStimulus(input logic [31:0] word, input logic en);
    @(negedge clk);
    i_data_read = word;
    ID          = en;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] functTab [12] = '{6'h20, 6'h24, 6'h25, 6'h28, 6'h2C, 6'h04,
                                6'h2F, 6'h29, 6'h07, 6'h06, 6'h22, 6'h26};

  initial begin
    reset       = 1'b1;
    ID          = 1'b1;
    i_data_read = 32'h01B83020;

    // Reset held with ID=1 keeps everything at NOP
    repeat (2) @(posedge clk);
    #1;
    checkDecode("reset", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h0, 0);

    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'h01B83020, 1'b1);
    checkDecode("ADD", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd13,5'd24,5'd6, 32'h0, 0);

    // R-type sweep, registers 13/24/6
    for (int k = 0; k < 12; k++) begin
      applyStimulus({26'h006E0C0, functTab[k]}, 1'b1);
      checkDecode($sformatf("R%0d", k), 0,0,0,0, 2'b00,2'b00, 4'(k),
                  5'd13,5'd24,5'd6, 32'h0, 0);
    end

    applyStimulus(32'h09B83026, 1'b1);
    checkDecode("J", 0,0,0,0, 2'b11,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h01B83026, 0);

    applyStimulus(32'h0DB83026, 1'b1);
    checkDecode("JAL", 0,0,1,1, 2'b11,2'b00, 4'd0, 5'd0,5'd0,5'd31, 32'h01B83026, 0);

    applyStimulus(32'h21B83026, 1'b1);
    checkDecode("ADDI", 0,0,1,0, 2'b00,2'b00, 4'd0, 5'd13,5'd0,5'd24, 32'h00003026, 0);

    applyStimulus(32'h3DB83026, 1'b1);
    checkDecode("LHI", 0,0,1,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd24, 32'h30260000, 0);

    applyStimulus(32'hADB83026, 1'b1);
    checkDecode("SW", 1,0,1,0, 2'b00,2'b00, 4'd0, 5'd13,5'd24,5'd0, 32'h00003026, 0);

    applyStimulus(32'h8DB83026, 1'b1);
    checkDecode("LW", 0,1,1,0, 2'b00,2'b00, 4'd0, 5'd13,5'd0,5'd24, 32'h00003026, 0);

    applyStimulus(32'h11B8F026, 1'b1);
    checkDecode("BEQZ", 0,0,1,0, 2'b01,2'b00, 4'd0, 5'd13,5'd0,5'd0, 32'hFFFFF026, 0);

    applyStimulus(32'h15B83026, 1'b1);
    checkDecode("BNEZ", 0,0,1,0, 2'b10,2'b00, 4'd0, 5'd13,5'd0,5'd0, 32'h00003026, 0);

    applyStimulus(32'h31B8F026, 1'b1);
    checkDecode("ANDI", 0,0,1,0, 2'b00,2'b00, 4'd1, 5'd13,5'd0,5'd24, 32'h0000F026, 0);

    applyStimulus(32'h5DB8F026, 1'b1);
    checkDecode("SRAI", 0,0,1,0, 2'b00,2'b00, 4'd8, 5'd13,5'd0,5'd24, 32'h0000F026, 0);

    applyStimulus(32'h69B8F026, 1'b1);
    checkDecode("SLTI", 0,0,1,0, 2'b00,2'b00, 4'd6, 5'd13,5'd0,5'd24, 32'hFFFFF026, 0);

    applyStimulus(32'h4DB83026, 1'b1);
    checkDecode("JALR", 0,0,1,1, 2'b11,2'b01, 4'd0, 5'd13,5'd0,5'd31, 32'h00003026, 0);

    applyStimulus(32'h49B83026, 1'b1);
    checkDecode("JR", 0,0,1,0, 2'b11,2'b01, 4'd0, 5'd13,5'd0,5'd0, 32'h00003026, 0);

    // ID=0: outputs hold the JR decode while the input changes
    applyStimulus(32'h21B83026, 1'b0);
    applyStimulus(32'hFDB83026, 1'b0);
    checkDecode("hold", 0,0,1,0, 2'b11,2'b01, 4'd0, 5'd13,5'd0,5'd0, 32'h00003026, 0);

    applyStimulus(32'hFDB83026, 1'b1);
    checkDecode("op3F", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h0, 1);

    // Illegal flag holds with ID=0
    applyStimulus(32'h01B83020, 1'b0);
    checkDecode("holdIll", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h0, 1);

    applyStimulus(32'h01B8303F, 1'b1);
    checkDecode("badFunct", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h0, 1);

    applyStimulus(32'h01B83022, 1'b1);
    checkDecode("SUB", 0,0,0,0, 2'b00,2'b00, 4'd10, 5'd13,5'd24,5'd6, 32'h0, 0);

    // Asynchronous reset mid-stream, between edges, overrides ID
    @(posedge clk);
    #3;
    i_data_read = 32'h21B83026;
    ID          = 1'b1;
    reset       = 1'b1;
    #1;
    checkDecode("asyncRst", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h0, 0);
    @(posedge clk);
    #1;
    checkDecode("rstHeld", 0,0,0,0, 2'b00,2'b00, 4'd0, 5'd0,5'd0,5'd0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'h21B83026, 1'b1);
    checkDecode("postRst", 0,0,1,0, 2'b00,2'b00, 4'd0, 5'd13,5'd0,5'd24, 32'h00003026, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dlx_decoder.md
Name: dlx_decoder

Overview:
- Instruction decode stage of the DLX core: takes the 32-bit fetched word and produces registered control, register indices and extended immediate for the register file, ALU, data memory and PC unit.
- Supports 12 R-type, 2 J-type and 19 I-type instructions.
- Outputs update only when the ID stage enable is high.

Parameters:
- None. All encodings are fixed constants in dlx_pkg.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ID  in  1  decode enable; outputs load only when 1
- i_data_read  in  32  fetched instruction
- d_write_enable  out  1  data-memory store (SW)
- d_load_enable  out  1  data-memory load (LW)
- Iv_alu  out  1  ALU operand B = Iv (0: = reg[Rs2])
- Pc_alu  out  1  ALU operand A = PC (0: = reg[Rs1])
- Pc_cmd  out  2  00 sequential, 01 branch if reg[Rs1]==0, 10 branch if reg[Rs1]!=0, 11 unconditional jump
- Pc_val  out  2  target: 00 PC+4+Iv, 01 reg[Rs1], 10/11 reserved (never driven)
- I  out  4  ALU op: ADD0 AND1 OR2 SEQ3 SLE4 SLL5 SLT6 SNE7 SRA8 SRL9 SUB10 XOR11; 12-15 unused
- Rs1, Rs2, Rd  out  5 each  register indices; Rd=0 means no writeback
- Iv  out  32  extended immediate

Behaviour:
- All outputs are flops. Asynchronous reset clears every output to 0, which is a NOP.
- On a rising edge with ID=1, outputs take the decode of i_data_read, giving one-cycle latency. With ID=0, all outputs hold.
- Unrecognised opcode or funct decodes as a NOP (all outputs 0).
- Opcode is [31:26].
- R-type, opcode 0x00:
  - Rs1=[25:21], Rs2=[20:16], Rd=[15:11], Iv=0, Iv_alu=0.
  - funct [5:0]: 0x20 ADD, 0x24 AND, 0x25 OR, 0x28 SEQ, 0x2C SLE, 0x04 SLL, 0x2F SLT, 0x29 SNE, 0x07 SRA, 0x06 SRL, 0x22 SUB, 0x26 XOR.
- J (0x02) and JAL (0x03):
  - Iv = sign-extended [25:0].
  - Pc_cmd=11, Pc_val=00.
  - J: Rd=0, all other fields 0.
  - JAL (link): Rd=31, Pc_alu=1, Iv_alu=1, I=ADD. JAL's Iv is the jump offset, so the link value is computed by the PC unit. The ALU path is only used when Iv=4 is forced; here Iv stays the offset.
- I-type common fields: Rs1=[25:21], Rd=[20:16], Rs2=0, imm=[15:0], Iv_alu=1.
- I-type, sign-extended imm:
  - ALU ops: ADDI 0x08, SUBI 0x0A, SEQI 0x18, SLEI 0x1C, SLTI 0x1A, SNEI 0x19 map to their ALU op.
  - LW 0x23: I=ADD, d_load_enable=1.
  - SW 0x2B: I=ADD, d_write_enable=1, Rs2=[20:16], Rd=0.
  - BEQZ 0x04 / BNEZ 0x05: Pc_cmd=01/10, Pc_val=00, Rd=0.
- I-type, zero-extended imm: ANDI 0x0C, ORI 0x0D, XORI 0x0E, SLLI 0x14, SRLI 0x16, SRAI 0x17.
- LHI 0x0F: Iv={imm,16'h0}, Rs1=0, I=ADD.
- JR 0x12: Pc_cmd=11, Pc_val=01, Rd=0.
- JALR 0x13: as JR, plus Rd=31, Pc_alu=1, I=ADD.
- Reset asserted mid-stream overrides ID. The first decode happens on the first edge after deassertion.

Optional Feature:
- Macro DLX_DECODER_ILLEGAL_EN.
- When defined: extra output port illegal (1 bit). It is registered with the other outputs, set to 1 for an unrecognised opcode/funct (the decode is still a NOP), cleared by reset, and held when ID=0.
- When undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- dlx_pkg holds:
  - opcode and funct localparams/enums;
  - ALU op enum (4 bits);
  - Pc_cmd and Pc_val encodings;
  - a NOP default struct.
- One sub-module, dlx_imm_ext: combinational; inputs imm[15:0], off[25:0] and mode (sext16/zext16/hi16/sext26); output 32 bits.
- The main block is a combinational decode case plus the output register.

Test Plan:
- Reset held, ID=1 → all outputs 0. Release reset, ADD 0x01B83020 → next edge Rs1=13, Rs2=24, Rd=6, I=0, Iv_alu=0, Pc_cmd=00.
- Sweep all 12 R funct values with fields 13/24/6 → I = 0,1,2,3,4,5,6,7,8,9,10,11 respectively, registers unchanged.
- J 0x09B83026 → Pc_cmd=11, Pc_val=00, Iv=0x01B83026, Rd=0. JAL 0x0DB83026 → same target, Rd=31, Pc_alu=1.
- ADDI 0x21B83026 → Rs1=13, Rd=24, Rs2=0, Iv=0x00003026, Iv_alu=1, I=0. LHI 0x3DB83026 → Iv=0x30260000, Rs1=0. SW 0xADB83026 → d_write_enable=1, Rs2=24, Rd=0. LW 0x8DB83026 → d_load_enable=1, Rd=24.
- BEQZ 0x11B8F026 → Pc_cmd=01, Iv=0xFFFFF026. ANDI 0x31B8F026 → Iv=0x0000F026. JR 0x49B83026 → Pc_cmd=11, Pc_val=01, Rd=0.
- ID=0 while i_data_read changes → outputs hold. Opcode 0x3F → NOP (illegal=1 when DLX_DECODER_ILLEGAL_EN is defined).
